// File: rtl/par16_bus_rx_if.sv
// Parallel-bus and word-handshake signals of par16_bus_rx.
// slave = receiver front end, master = host/cmd_parser side.
interface par16_bus_rx_if;
    logic        bus_clk;
    logic        bus_rnw;
    logic [15:0] bus_data_in;
    logic [15:0] bus_data_out;
    logic        bus_data_oe;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  bus_clk, bus_rnw, bus_data_in, tx_data, tx_valid,
        output bus_data_out, bus_data_oe, rx_data, rx_valid, tx_ready
    );

    modport master (
        output bus_clk, bus_rnw, bus_data_in, tx_data, tx_valid,
        input  bus_data_out, bus_data_oe, rx_data, rx_valid, tx_ready
    );
endinterface

// File: rtl/par16_bus_rx.sv
// Slave front end for the 16-bit Raspberry Pi parallel bus: synchronisers, B8B8/8B8B sync hunt,
// write-strobe capture and read-strobe serving. Define PAR16_RX_COUNT_EN to build the rx word counter.
module par16_bus_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] SYNC_WORD0  = 16'hB8B8,
    parameter logic [15:0] SYNC_WORD1  = 16'h8B8B
) (
    input  logic               clk,
    input  logic               reset,
    par16_bus_rx_if.slave      bus,
    output logic               synced,
    output logic               tx_underflow,
    output logic [15:0]        rx_word_count
);

    typedef enum logic [1:0] {HUNT0, HUNT1, SYNCED} state_t;

    logic [SYNC_STAGES-1:0]       r_clk_sync;
    logic [SYNC_STAGES-1:0]       r_rnw_sync;
    logic [SYNC_STAGES-1:0][15:0] r_data_sync;
    logic                         r_clk_d;

    logic                         w_clk_s;
    logic                         w_rnw_s;
    logic [15:0]                  w_data_s;
    logic                         w_rise;
    logic                         w_fall;
    logic                         w_qual;
    logic                         w_held2;

    state_t                       r_state;
    logic                         r_prev_qual;
    logic [15:0]                  r_prev_data;
    logic                         r_synced;
    logic [15:0]                  r_rx_data;
    logic                         r_rx_valid;
    logic                         r_tx_ready;
    logic [15:0]                  r_data_out;
    logic                         r_oe;
    logic                         r_underflow;
`ifdef PAR16_RX_COUNT_EN
    logic [15:0]                  r_rx_count;
`endif

    // NOTE: the synchroniser chains are plain flops, not a memory, so they take the async reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '0;
            r_rnw_sync  <= '0;
            r_data_sync <= '0;
            r_clk_d     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift on the same edge without ordering races.
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.bus_clk};
            r_rnw_sync  <= {r_rnw_sync[SYNC_STAGES-2:0], bus.bus_rnw};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.bus_data_in};
            r_clk_d     <= w_clk_s;
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_rnw_s  = r_rnw_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_rise   = w_clk_s & ~r_clk_d;
    assign w_fall   = ~w_clk_s & r_clk_d;

    // A sync word only counts once it has been seen on two consecutive strobe-high write cycles.
    assign w_qual   = w_clk_s & ~w_rnw_s;
    assign w_held2  = w_qual & r_prev_qual & (w_data_s == r_prev_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= HUNT0;
            r_prev_qual <= 1'b0;
            r_prev_data <= '0;
            r_synced    <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_data_out  <= '0;
            r_oe        <= 1'b0;
            r_underflow <= 1'b0;
`ifdef PAR16_RX_COUNT_EN
            r_rx_count  <= '0;
`endif
        end else begin
            r_prev_qual <= w_qual;
            r_prev_data <= w_data_s;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            case (r_state)
                HUNT0: begin
                    if (w_held2 && w_data_s == SYNC_WORD0) r_state <= HUNT1;
                end
                HUNT1: begin
                    if (w_held2) begin
                        if (w_data_s == SYNC_WORD1) begin
                            r_state  <= SYNCED;
                            r_synced <= 1'b1;
                        end else if (w_data_s != SYNC_WORD0) begin
                            r_state  <= HUNT0;
                        end
                    end
                end
                SYNCED: begin
                    r_oe <= w_rnw_s;
                    if (w_rise && !w_rnw_s) begin
                        r_rx_data  <= w_data_s;
                        r_rx_valid <= 1'b1;
`ifdef PAR16_RX_COUNT_EN
                        r_rx_count <= r_rx_count + 16'd1;
`endif
                    end
                    if (w_fall && w_rnw_s) begin
                        if (bus.tx_valid) begin
                            r_data_out <= bus.tx_data;
                            r_tx_ready <= 1'b1;
                        end else begin
                            r_data_out  <= '0;
                            r_underflow <= 1'b1;
                        end
                    end
                end
                default: r_state <= HUNT0;
            endcase
        end
    end

    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.tx_ready     = r_tx_ready;
    assign bus.bus_data_out = r_data_out;
    assign bus.bus_data_oe  = r_oe;
    assign synced           = r_synced;
    assign tx_underflow     = r_underflow;
`ifdef PAR16_RX_COUNT_EN
    assign rx_word_count    = r_rx_count;
`else
    assign rx_word_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_par16_bus_rx.sv
// Randomised self-checking bench for par16_bus_rx against a transaction-level host/receiver model.
module tb_par16_bus_rx;

    localparam int SYNC_STAGES = 2;

    logic        clk;
    logic        reset;
    logic        synced;
    logic        tx_underflow;
    logic [15:0] rx_word_count;

    par16_bus_rx_if bus_if ();

    par16_bus_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if.slave),
        .synced        (synced),
        .tx_underflow  (tx_underflow),
        .rx_word_count (rx_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: what the host has done, in transaction terms.
    logic [15:0] m_count;
    logic        m_underflow;
    logic [15:0] m_last_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef PAR16_RX_COUNT_EN
        return m_count;
`else
        return 16'h0000;
`endif
    endfunction

    // Hold a word on the pins with the strobe high in write mode for n clk cycles.
    task automatic drive_word(input logic [15:0] w, input int n);
        bus_if.bus_clk     = 1'b1;
        bus_if.bus_rnw     = 1'b0;
        bus_if.bus_data_in = w;
        repeat (n) @(negedge clk);
    endtask

    task automatic poll_synced(input string tag, input logic exp, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (synced) seen = 1'b1;
        end
        check(tag, seen, exp);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] w, input bit accept);
        int          pulses = 0;
        int          lat    = 0;
        int          oe_hi  = 0;
        logic [15:0] got    = '0;
        bus_if.bus_rnw     = 1'b0;
        bus_if.bus_clk     = 1'b0;
        bus_if.bus_data_in = w;
        repeat (3) @(negedge clk);
        bus_if.bus_clk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus_if.bus_data_oe) oe_hi++;
            if (bus_if.rx_valid) begin
                pulses++;
                if (lat == 0) lat = i;
                got = bus_if.rx_data;
            end
        end
        @(negedge clk);
        bus_if.bus_clk = 1'b0;
        repeat (4) @(negedge clk);
        check("wr_no_oe", oe_hi, 0);
        if (accept) begin
            m_count   = m_count + 16'd1;
            m_last_rx = w;
            check("wr_pulses", pulses, 1);
            check("wr_latency", lat, SYNC_STAGES + 1);
            check("wr_data", got, w);
        end else begin
            check("wr_ignored", pulses, 0);
        end
    endtask

    task automatic do_read(input bit valid, input logic [15:0] word);
        int          ready_n = 0;
        int          rx_n    = 0;
        logic [15:0] exp     = valid ? word : 16'h0000;
        bus_if.bus_clk  = 1'b0;
        bus_if.bus_rnw  = 1'b1;
        bus_if.tx_valid = valid;
        bus_if.tx_data  = word;
        repeat (4) @(negedge clk);
        check("rd_oe_on", bus_if.bus_data_oe, 1'b1);
        bus_if.bus_clk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ready_n += int'(bus_if.tx_ready);
            rx_n    += int'(bus_if.rx_valid);
        end
        @(negedge clk);
        check("rd_rise_noready", ready_n, 0);
        bus_if.bus_clk = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 2; i++) begin
            @(posedge clk); #1;
            ready_n += int'(bus_if.tx_ready);
            rx_n    += int'(bus_if.rx_valid);
        end
        check("rd_data", bus_if.bus_data_out, exp);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ready_n += int'(bus_if.tx_ready);
            rx_n    += int'(bus_if.rx_valid);
        end
        check("rd_ready", ready_n, valid ? 1 : 0);
        if (!valid) m_underflow = 1'b1;
        check("rd_underflow", tx_underflow, m_underflow);
        @(negedge clk);
        bus_if.bus_rnw  = 1'b0;
        bus_if.tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_oe_off", bus_if.bus_data_oe, 1'b0);
        check("rd_no_rx", rx_n, 0);
    endtask

    task automatic good_sync(input string tag);
        drive_word(16'hB8B8, 3);
        drive_word(16'h8B8B, 3);
        poll_synced(tag, 1'b1, 4);
        bus_if.bus_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_model();
        m_count     = '0;
        m_underflow = 1'b0;
        m_last_rx   = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus_if.bus_clk     = 1'b0;
        bus_if.bus_rnw     = 1'b0;
        bus_if.bus_data_in = '0;
        bus_if.tx_data     = '0;
        bus_if.tx_valid    = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_synced", synced, 1'b0);
        check("rst_rx_valid", bus_if.rx_valid, 1'b0);
        check("rst_rx_data", bus_if.rx_data, 16'h0);
        check("rst_tx_ready", bus_if.tx_ready, 1'b0);
        check("rst_data_out", bus_if.bus_data_out, 16'h0);
        check("rst_oe", bus_if.bus_data_oe, 1'b0);
        check("rst_underflow", tx_underflow, 1'b0);
        check("rst_count", rx_word_count, 16'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Strobes before sync are ignored.
        do_write(16'h0001, 1'b0);

        // A broken pair falls back to HUNT0.
        drive_word(16'hB8B8, 3);
        drive_word(16'h1234, 3);
        drive_word(16'h8B8B, 3);
        poll_synced("hunt_broken", 1'b0, 4);
        good_sync("hunt_good");

        do_write(16'h0005, 1'b1);
        do_write(16'h00B8, 1'b1);

        do_read(1'b1, 16'h0064);
        do_read(1'b0, 16'hA5A5);
        do_write(16'h3C3C, 1'b1);
        check("underflow_sticky", tx_underflow, 1'b1);

        for (int k = 0; k < 200; k++) begin
            do_write(16'($urandom), 1'b1);
            if ($urandom_range(0, 5) == 0)
                do_read($urandom_range(0, 3) != 0, 16'($urandom));
        end
        check("rx_data_hold", bus_if.rx_data, m_last_rx);
        check("underflow_end", tx_underflow, m_underflow);
        check("word_count", rx_word_count, exp_count());

        // Reset in the middle of a write strobe.
        bus_if.bus_rnw     = 1'b0;
        bus_if.bus_data_in = 16'h7777;
        bus_if.bus_clk     = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midwr_synced", synced, 1'b0);
        check("midwr_count", rx_word_count, 16'h0);
        check("midwr_rx_valid", bus_if.rx_valid, 1'b0);
        reset_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_if.bus_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a read with oe asserted.
        good_sync("resync");
        bus_if.bus_rnw  = 1'b1;
        bus_if.tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("midrd_oe_pre", bus_if.bus_data_oe, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrd_oe", bus_if.bus_data_oe, 1'b0);
        check("midrd_synced", synced, 1'b0);
        check("midrd_underflow", tx_underflow, 1'b0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/par16_bus_rx.md
Name: par16_bus_rx

Overview:
- Slave-side front end for the 16-bit Raspberry Pi parallel bus (bus_clk, bus_data, bus_rnw), sitting directly upstream of cmd_parser inside top_md5.
- Synchronises the asynchronous bus signals into the clk domain and performs the B8B8/8B8B sync handshake.
- Turns host write strobes into one-cycle rx word pulses for cmd_parser.
- Serves host read strobes from a tx word handshake driven by cmd_parser. Tristate buffering is done in top_md5 from bus_data_out/bus_data_oe.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronisers on bus_clk, bus_rnw and bus_data; minimum 2.
- SYNC_WORD0, 16'hB8B8: first sync word.
- SYNC_WORD1, 16'h8B8B: second sync word.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- bus_clk  in  1  host strobe, asynchronous to clk.
- bus_rnw  in  1  1 = host read, 0 = host write.
- bus_data_in  in  16  bus value seen at the pins.
- bus_data_out  out  16  word driven to the host on reads.
- bus_data_oe  out  1  tristate enable for bus_data.
- synced  out  1  sync handshake complete.
- rx_data  out  16  captured host write word.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- tx_data  in  16  next word for the host.
- tx_valid  in  1  tx_data available.
- tx_ready  out  1  one-cycle pulse; tx_data consumed.
- tx_underflow  out  1  sticky flag: a host read found tx_valid low.
- rx_word_count  out  16  accepted write count (see Optional Feature).

Behaviour:
- Reset (async, immediate): synced=0, rx_valid=0, rx_data=0, tx_ready=0, bus_data_out=0, bus_data_oe=0, tx_underflow=0, rx_word_count=0, FSM=HUNT0, sync chains cleared.
- Synchronisers: bus_clk, bus_rnw and all 16 data bits use equal-depth chains. The host holds data stable for at least 3 clk cycles around strobe edges, so sampling the synced data is safe.
- Edge detect: one extra register behind the bus_clk chain. rise = synced high && delayed low; fall = the reverse.
- FSM state HUNT0:
  - Acts only while synced bus_clk=1 and synced bus_rnw=0.
  - SYNC_WORD0 on the synced data for 2 consecutive clk cycles -> HUNT1.
- FSM state HUNT1:
  - SYNC_WORD1 for 2 consecutive cycles -> SYNCED.
  - Any value other than SYNC_WORD0 or SYNC_WORD1 held 2 cycles -> HUNT0.
  - SYNC_WORD0 keeps the FSM in HUNT1.
- FSM state SYNCED:
  - synced=1.
  - Left only by reset; there is no in-band resync.
  - Before SYNCED, all strobes are ignored: no rx_valid, no tx_ready, oe=0.
- Write path (SYNCED, bus_rnw=0):
  - On rise, rx_data <= synced data and rx_valid=1 for exactly one cycle.
  - Latency: rx_valid is high after posedge SYNC_STAGES+1, counted from the first posedge that samples bus_clk=1.
  - No backpressure; cmd_parser must accept every pulse.
  - rx_data holds its value until the next write.
- Read path (SYNCED, bus_rnw=1):
  - bus_data_oe=1 while synced bus_rnw=1; it drops the cycle after synced bus_rnw=0.
  - On fall with tx_valid=1: bus_data_out <= tx_data, tx_ready pulses one cycle.
  - On fall with tx_valid=0: bus_data_out <= 16'h0000, tx_underflow <= 1 (sticky until reset), no tx_ready.
  - The word is stable within SYNC_STAGES+2 cycles of the pin fall, i.e. before the host rise plus 3 cycles.
  - Rise in read mode has no effect.
- Simultaneous rnw change and strobe edge: the mode is the synced bus_rnw value in the edge-detect cycle.
- Writes never assert oe. Reads never assert rx_valid.

Optional Feature:
- Macro: PAR16_RX_COUNT_EN.
- Defined:
  - rx_word_count increments by 1 on each rx_valid pulse.
  - It wraps 16'hFFFF -> 0 and resets to 0. It feeds the LEDs for debug.
- Undefined: rx_word_count is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset, then hold bus_clk=1, drive B8B8 for 3 cycles, then 8B8B for 3 cycles -> synced=1 within 4 cycles. With no sync, a write of 16'h0001 gives no rx_valid.
- After sync, write 16'h0005 then 16'h00B8 (CMD_STR_LEN, 23*8) -> two single-cycle rx_valid pulses with rx_data 16'h0005 then 16'h00B8. Each pulse lands SYNC_STAGES+1 cycles after bus_clk high.
- B8B8, then 1234 for 3 cycles, then 8B8B -> remains unsynced (HUNT0). A correct B8B8/8B8B pair afterwards -> synced=1.
- Synced, tx_valid=1, tx_data=16'h0064, host read -> oe=1, bus_data_out=16'h0064 before the host sample point, one tx_ready pulse.
- Synced, tx_valid=0, host read -> bus_data_out=16'h0000, tx_underflow=1 and held; later writes unaffected.
- With PAR16_RX_COUNT_EN, 200 writes -> rx_word_count=200. Assert reset mid-write -> count=0, oe=0, synced=0 immediately.
